// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types for the AXI read-channel arbiter
package axi_arb_pkg;

   typedef enum logic [1:0] {IDLE, START, BURST, GAP} arb_state_t;
   typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_t;

endpackage

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - grants the AXI read master to the I- or D-cache refill FSM
// ARB_ROUND_ROBIN_EN: alternate ties between requesters; undefined gives data fixed priority
module axi_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter int  BLOCK_BEATS = 16,
   localparam int CNT_W       = $clog2(BLOCK_BEATS) + 1
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             i_req_instr,
   input  logic             i_req_data,
   input  logic             i_r_valid,
   input  logic             i_r_last,
   output logic             o_gnt_instr,
   output logic             o_gnt_data,
   output logic             o_start_read,
   output logic             o_addr_sel,
   output logic             o_done_instr,
   output logic             o_done_data,
   output logic [CNT_W-1:0] o_beat_cnt,
   output logic             o_len_err
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BEATS - 1);

   arb_state_t       state_q, state_d;
   arb_owner_t       owner_q, owner_d, winner;
   logic             addr_sel_q, addr_sel_d;
   logic             len_err_q, len_err_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             owner_gnt, done_beat;

`ifdef ARB_ROUND_ROBIN_EN
   arb_owner_t rr_q, rr_d;

   always_comb begin
      if (i_req_instr && i_req_data) winner = (rr_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
      else if (i_req_data)           winner = OWN_DATA;
      else                           winner = OWN_INSTR;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) rr_q <= OWN_DATA;
      else        rr_q <= rr_d;
   end
`else
   // A data miss stalls the core longer, so data always wins a tie.
   always_comb winner = i_req_data ? OWN_DATA : OWN_INSTR;
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_sel_d   = addr_sel_q;
      beat_cnt_d   = beat_cnt_q;
      len_err_d    = len_err_q;
      owner_gnt    = 1'b0;
      done_beat    = 1'b0;
      o_start_read = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_d         = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_req_instr || i_req_data) begin
               owner_d    = winner;
               addr_sel_d = (winner == OWN_DATA);
               state_d    = START;
            end
         end
         START: begin
            o_start_read = 1'b1;
            owner_gnt    = 1'b1;
            beat_cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d         = owner_q;
`endif
            state_d      = BURST;
         end
         BURST: begin
            owner_gnt = 1'b1;
            if (i_r_valid && beat_cnt_q != FULL_CNT) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (i_r_valid && i_r_last) begin
               done_beat = 1'b1;
               // The counter has not yet absorbed this beat, so a full burst ends at LAST_CNT.
               if (beat_cnt_q != LAST_CNT) len_err_d = 1'b1;
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q    <= IDLE;
         owner_q    <= OWN_INSTR;
         addr_sel_q <= 1'b0;
         beat_cnt_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_sel_q <= addr_sel_d;
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
      end
   end

   assign o_gnt_instr  = owner_gnt && (owner_q == OWN_INSTR);
   assign o_gnt_data   = owner_gnt && (owner_q == OWN_DATA);
   assign o_done_instr = done_beat && (owner_q == OWN_INSTR);
   assign o_done_data  = done_beat && (owner_q == OWN_DATA);
   assign o_addr_sel   = addr_sel_q;
   assign o_beat_cnt   = beat_cnt_q;
   assign o_len_err    = len_err_q;

endmodule
